// File: rtl/ins_decode_if.sv
// Signal bundle between the instruction decoder and the datapath / memory side.
// The master drives instruction bytes and enables; the slave (decoder) returns state and strobes.
interface ins_decode_if;
   logic [7:0] ram_data;
   logic       ir_ld;
   logic       sm_en;
   logic       cf_en;
   logic       zf_en;
   logic       alu_cy;
   logic       alu_zero;

   logic [7:0] ir;
   logic       sm;
   logic       c;
   logic       z;
   logic       mova, movb, movc, add, sub, and1, not1, rsr, rsl;
   logic       jmp, jz, jc, in1, out1, nop, halt;
   logic       illegal;
   logic       halted;

   modport master (
      output ram_data, ir_ld, sm_en, cf_en, zf_en, alu_cy, alu_zero,
      input  ir, sm, c, z, mova, movb, movc, add, sub, and1, not1, rsr, rsl,
             jmp, jz, jc, in1, out1, nop, halt, illegal, halted
   );

   modport slave (
      input  ram_data, ir_ld, sm_en, cf_en, zf_en, alu_cy, alu_zero,
      output ir, sm, c, z, mova, movb, movc, add, sub, and1, not1, rsr, rsl,
             jmp, jz, jc, in1, out1, nop, halt, illegal, halted
   );
endinterface

// File: rtl/ins_decode_fsm.sv
// Instruction register, fetch/execute phase sequencer, carry/zero flags and one-hot
// instruction decoder. Executing halt freezes the IR and phase until reset.
module ins_decode_fsm (
   input logic        clk,
   input logic        rst,
   ins_decode_if.slave bus
);

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      EXECUTE = 2'd1,
      HALTED  = 2'd2
   } phase_t;

   phase_t     state, state_next;
   logic [7:0] ir_q;
   logic       c_q, z_q;
   logic       exec;
   logic [3:0] op;
   logic [1:0] lo;

   logic mova, movb, movc, add, sub, and1, not1, rsr, rsl;
   logic jmp, jz, jc, in1, out1, nop, halt, illegal;

   assign exec = (state != FETCH);
   assign op   = ir_q[7:4];
   assign lo   = ir_q[1:0];

   // NOTE: sequential state is written with non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
         ir_q  <= 8'h00;
         c_q   <= 1'b0;
         z_q   <= 1'b0;
      end else begin
         state <= state_next;
         // The halt strobe itself is the freeze condition: ir must keep the halt opcode.
         if (bus.ir_ld && !halt) ir_q <= bus.ram_data;
         if (bus.cf_en)          c_q  <= bus.alu_cy;
         if (bus.zf_en)          z_q  <= bus.alu_zero;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         FETCH:   if (bus.sm_en) state_next = EXECUTE;
         EXECUTE: begin
            if (halt)            state_next = HALTED;
            else if (bus.sm_en)  state_next = FETCH;
         end
         HALTED:  state_next = HALTED;
         default: state_next = FETCH;
      endcase
   end

   // NOTE: every strobe gets a default before the case so no path through this block
   // leaves a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      mova = 1'b0; movb = 1'b0; movc = 1'b0; add  = 1'b0;
      sub  = 1'b0; and1 = 1'b0; not1 = 1'b0; rsr  = 1'b0;
      rsl  = 1'b0; jmp  = 1'b0; jz   = 1'b0; jc   = 1'b0;
      in1  = 1'b0; out1 = 1'b0; nop  = 1'b0; halt = 1'b0;
      illegal = 1'b0;
      if (exec) begin
         case (op)
            4'b1100: mova = 1'b1;
            4'b1101: movb = 1'b1;
            4'b1110: movc = 1'b1;
            4'b1001: add  = 1'b1;
            4'b0110: sub  = 1'b1;
            4'b1011: and1 = 1'b1;
            4'b0101: not1 = 1'b1;
            4'b0010: in1  = 1'b1;
            4'b0100: out1 = 1'b1;
            4'b0111: nop  = 1'b1;
            4'b1000: halt = 1'b1;
            4'b1010: begin
               case (lo)
                  2'b00:   rsr = 1'b1;
                  2'b11:   rsl = 1'b1;
                  default: begin nop = 1'b1; illegal = 1'b1; end
               endcase
            end
            4'b0011: begin
               case (lo)
                  2'b00:   jmp = 1'b1;
                  2'b01:   jz  = 1'b1;
                  2'b10:   jc  = 1'b1;
                  default: begin nop = 1'b1; illegal = 1'b1; end
               endcase
            end
            default: begin nop = 1'b1; illegal = 1'b1; end
         endcase
      end
   end

   assign bus.ir      = ir_q;
   assign bus.sm      = exec;
   assign bus.c       = c_q;
   assign bus.z       = z_q;
   assign bus.halted  = (state == HALTED);
   assign bus.mova    = mova;
   assign bus.movb    = movb;
   assign bus.movc    = movc;
   assign bus.add     = add;
   assign bus.sub     = sub;
   assign bus.and1    = and1;
   assign bus.not1    = not1;
   assign bus.rsr     = rsr;
   assign bus.rsl     = rsl;
   assign bus.jmp     = jmp;
   assign bus.jz      = jz;
   assign bus.jc      = jc;
   assign bus.in1     = in1;
   assign bus.out1    = out1;
   assign bus.nop     = nop;
   assign bus.halt    = halt;
   assign bus.illegal = illegal;

endmodule
